gx_rst_ctrl_xn: RTL



---
 rtl/gx_rst_ctrl_xn.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/gx_rst_ctrl_xn.sv
// Per-channel TX/RX reset sequencer for Arria 10 GX standard-PCS transceivers.
// Optional macro GX_RST_STATUS_SYNC_EN adds 2-flop synchronisers on the status inputs.
module gx_rst_ctrl_xn #(
  parameter int NUM_CHANNELS = 1,
  parameter int T_TX_ANALOG  = 8,
  parameter int T_TX_DIGITAL = 16,
  parameter int T_RX_ANALOG  = 8,
  parameter int T_LTD        = 32
) (
  input  logic                    mgmt_clk,
  input  logic                    mgmt_reset,
  input  logic                    pll_locked,
  input  logic [NUM_CHANNELS-1:0] tx_cal_busy,
  input  logic [NUM_CHANNELS-1:0] rx_cal_busy,
  input  logic [NUM_CHANNELS-1:0] rx_is_lockedtodata,
  input  logic [NUM_CHANNELS-1:0] tx_reset_req,
  input  logic [NUM_CHANNELS-1:0] rx_reset_req,
  output logic [NUM_CHANNELS-1:0] tx_analogreset,
  output logic [NUM_CHANNELS-1:0] tx_digitalreset,
  output logic [NUM_CHANNELS-1:0] rx_analogreset,
  output logic [NUM_CHANNELS-1:0] rx_digitalreset,
  output logic [NUM_CHANNELS-1:0] tx_ready,
  output logic [NUM_CHANNELS-1:0] rx_ready
);

  localparam int T_MAX_TX = (T_TX_ANALOG > T_TX_DIGITAL) ? T_TX_ANALOG : T_TX_DIGITAL;
  localparam int T_MAX_RX = (T_RX_ANALOG > T_LTD) ? T_RX_ANALOG : T_LTD;
  localparam int T_MAX    = (T_MAX_TX > T_MAX_RX) ? T_MAX_TX : T_MAX_RX;
  localparam int CW       = $clog2(T_MAX) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t TXA_END = cnt_t'(T_TX_ANALOG - 1);
  localparam cnt_t TXD_END = cnt_t'(T_TX_DIGITAL - 1);
  localparam cnt_t RXA_END = cnt_t'(T_RX_ANALOG - 1);
  localparam cnt_t LTD_END = cnt_t'(T_LTD - 1);

  // State bits are the registered outputs: {analogreset, digitalreset, ready}.
  typedef enum logic [2:0] {
    TX_RESET = 3'b110,
    TX_DIG   = 3'b010,
    TX_READY = 3'b001
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_RESET    = 3'b110,
    RX_WAIT_LTD = 3'b010,
    RX_READY    = 3'b001
  } rx_state_t;

  logic                    pl_s;
  logic [NUM_CHANNELS-1:0] tcb_s;
  logic [NUM_CHANNELS-1:0] rcb_s;
  logic [NUM_CHANNELS-1:0] ltd_s;

`ifdef GX_RST_STATUS_SYNC_EN
  logic [1:0]              pl_ff;
  logic [NUM_CHANNELS-1:0] tcb_ff1, tcb_ff2;
  logic [NUM_CHANNELS-1:0] rcb_ff1, rcb_ff2;
  logic [NUM_CHANNELS-1:0] ltd_ff1, ltd_ff2;

  // cal_busy flops come out of reset busy so nothing sequences until calibration reports done.
  always_ff @(posedge mgmt_clk) begin
    if (mgmt_reset) begin
      pl_ff   <= '0;
      tcb_ff1 <= '1;
      tcb_ff2 <= '1;
      rcb_ff1 <= '1;
      rcb_ff2 <= '1;
      ltd_ff1 <= '0;
      ltd_ff2 <= '0;
    end else begin
      pl_ff   <= {pl_ff[0], pll_locked};
      tcb_ff1 <= tx_cal_busy;
      tcb_ff2 <= tcb_ff1;
      rcb_ff1 <= rx_cal_busy;
      rcb_ff2 <= rcb_ff1;
      ltd_ff1 <= rx_is_lockedtodata;
      ltd_ff2 <= ltd_ff1;
    end
  end

  assign pl_s  = pl_ff[1];
  assign tcb_s = tcb_ff2;
  assign rcb_s = rcb_ff2;
  assign ltd_s = ltd_ff2;
`else
  assign pl_s  = pll_locked;
  assign tcb_s = tx_cal_busy;
  assign rcb_s = rx_cal_busy;
  assign ltd_s = rx_is_lockedtodata;
`endif

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    tx_state_t tx_st;
    rx_state_t rx_st;
    cnt_t      tx_cnt;
    cnt_t      rx_cnt;

    // Priority: soft request > cal_busy > PLL loss > count completion.
    always_ff @(posedge mgmt_clk) begin
      if (mgmt_reset || tx_reset_req[i]) begin
        tx_st  <= TX_RESET;
        tx_cnt <= '0;
      end else if (tcb_s[i] && tx_st != TX_RESET) begin
        tx_st  <= TX_RESET;
        tx_cnt <= '0;
      end else if (!pl_s && tx_st != TX_RESET) begin
        tx_st  <= TX_DIG;
        tx_cnt <= '0;
      end else begin
        case (tx_st)
          TX_RESET: begin
            if (pl_s && !tcb_s[i]) begin
              if (tx_cnt == TXA_END) begin
                tx_st  <= TX_DIG;
                tx_cnt <= '0;
              end else if (tx_cnt != '1) begin
                tx_cnt <= tx_cnt + cnt_t'(1);
              end
            end else begin
              tx_cnt <= '0;
            end
          end
          TX_DIG: begin
            if (tx_cnt == TXD_END) begin
              tx_st  <= TX_READY;
              tx_cnt <= '0;
            end else if (tx_cnt != '1) begin
              tx_cnt <= tx_cnt + cnt_t'(1);
            end
          end
          TX_READY: tx_st <= TX_READY;
          default: begin
            tx_st  <= TX_RESET;
            tx_cnt <= '0;
          end
        endcase
      end
    end

    always_ff @(posedge mgmt_clk) begin
      if (mgmt_reset || rx_reset_req[i]) begin
        rx_st  <= RX_RESET;
        rx_cnt <= '0;
      end else if (rcb_s[i] && rx_st != RX_RESET) begin
        rx_st  <= RX_RESET;
        rx_cnt <= '0;
      end else if (!ltd_s[i] && rx_st == RX_READY) begin
        rx_st  <= RX_WAIT_LTD;
        rx_cnt <= '0;
      end else begin
        case (rx_st)
          RX_RESET: begin
            if (!rcb_s[i]) begin
              if (rx_cnt == RXA_END) begin
                rx_st  <= RX_WAIT_LTD;
                rx_cnt <= '0;
              end else if (rx_cnt != '1) begin
                rx_cnt <= rx_cnt + cnt_t'(1);
              end
            end else begin
              rx_cnt <= '0;
            end
          end
          RX_WAIT_LTD: begin
            if (!ltd_s[i]) begin
              rx_cnt <= '0;
            end else if (rx_cnt == LTD_END) begin
              rx_st  <= RX_READY;
              rx_cnt <= '0;
            end else if (rx_cnt != '1) begin
              rx_cnt <= rx_cnt + cnt_t'(1);
            end
          end
          RX_READY: rx_st <= RX_READY;
          default: begin
            rx_st  <= RX_RESET;
            rx_cnt <= '0;
          end
        endcase
      end
    end

    assign tx_analogreset[i]  = tx_st[2];
    assign tx_digitalreset[i] = tx_st[1];
    assign tx_ready[i]        = tx_st[0];
    assign rx_analogreset[i]  = rx_st[2];
    assign rx_digitalreset[i] = rx_st[1];
    assign rx_ready[i]        = rx_st[0];
  end

endmodule
